// File: rtl/vga_mode_ctrl.sv
// Display-mode and threshold controller: debounced pushbuttons stage mode/threshold changes,
// which reach the colour-out datapath only on a vsync falling edge so no frame tears.
module vga_mode_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter logic [7:0]  THR_DEFAULT     = 8'h80,
  parameter logic [7:0]  THR_STEP        = 8'h08
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_mode_n,
  input  logic       key_up_n,
  input  logic       key_dn_n,
  input  logic       vga_vs,
  output logic [1:0] mode,
  output logic [1:0] mode_pending,
  output logic [7:0] threshold,
  output logic       cfg_update
);

  localparam int unsigned     NumKeys = 3;
  localparam int unsigned     CntW    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ModeColour = 2'b00;
  localparam logic [1:0] ModeGray   = 2'b01;
  localparam logic [1:0] ModeBw     = 2'b10;

  typedef enum logic [1:0] {StRel, StChkDn, StHeld, StChkUp} key_st_e;

  // Key index: 0 = mode, 1 = up, 2 = down.
  logic [NumKeys-1:0] key_raw;
  logic [NumKeys-1:0] sync1_q, sync2_q;
  logic [NumKeys-1:0] press;

  assign key_raw = {key_dn_n, key_up_n, key_mode_n};

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= key_raw;
      sync2_q <= sync1_q;
    end
  end

  for (genvar k = 0; k < NumKeys; k++) begin : g_key
    key_st_e         st_q, st_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            press_ev;

    always_ff @(posedge clk) begin
      if (reset) begin
        st_q  <= StRel;
        cnt_q <= '0;
      end else begin
        st_q  <= st_d;
        cnt_q <= cnt_d;
      end
    end

    always_comb begin
      st_d     = st_q;
      cnt_d    = cnt_q;
      press_ev = 1'b0;
      unique case (st_q)
        StRel: begin
          if (!sync2_q[k]) begin
            st_d  = StChkDn;
            cnt_d = CntW'(1);
          end
        end
        StChkDn: begin
          if (sync2_q[k]) begin
            st_d  = StRel;
            cnt_d = '0;
          end else if (cnt_q >= CntLast) begin
            st_d     = StHeld;
            cnt_d    = '0;
            press_ev = 1'b1;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StHeld: begin
          if (sync2_q[k]) begin
            st_d  = StChkUp;
            cnt_d = CntW'(1);
          end
        end
        StChkUp: begin
          if (!sync2_q[k]) begin
            st_d  = StHeld;
            cnt_d = '0;
          end else if (cnt_q >= CntLast) begin
            st_d  = StRel;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        default: begin
          st_d  = StRel;
          cnt_d = '0;
        end
      endcase
    end

    assign press[k] = press_ev;
  end

  logic [1:0] mode_q, mode_d, mode_pend_q, mode_pend_d;
  logic [7:0] thr_q, thr_d, thr_stage_q, thr_stage_d;
  logic       cfg_update_q, cfg_update_d;
  logic       vs_q;
  logic       frame_edge;
  logic [8:0] thr_sum;
  logic [7:0] thr_up, thr_dn;

  assign frame_edge = vs_q & ~vga_vs;
  assign thr_sum    = {1'b0, thr_stage_q} + {1'b0, THR_STEP};
  assign thr_up     = thr_sum[8] ? 8'hFF : thr_sum[7:0];
  assign thr_dn     = (thr_stage_q < THR_STEP) ? 8'h00 : thr_stage_q - THR_STEP;

  always_comb begin
    mode_pend_d = mode_pend_q;
    thr_stage_d = thr_stage_q;
    if (press[0]) begin
      case (mode_pend_q)
        ModeColour: mode_pend_d = ModeGray;
        ModeGray:   mode_pend_d = ModeBw;
        default:    mode_pend_d = ModeColour;
      endcase
    end
    // Simultaneous up and down cancel out.
    if (press[1] && !press[2]) begin
      thr_stage_d = thr_up;
    end else if (press[2] && !press[1]) begin
      thr_stage_d = thr_dn;
    end
  end

  // Commit uses the staged values as held before this cycle's events.
  always_comb begin
    mode_d       = mode_q;
    thr_d        = thr_q;
    cfg_update_d = 1'b0;
    if (frame_edge) begin
      mode_d       = mode_pend_q;
      thr_d        = thr_stage_q;
      cfg_update_d = (mode_pend_q != mode_q) || (thr_stage_q != thr_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vs_q         <= 1'b0;
      mode_q       <= ModeColour;
      mode_pend_q  <= ModeColour;
      thr_q        <= THR_DEFAULT;
      thr_stage_q  <= THR_DEFAULT;
      cfg_update_q <= 1'b0;
    end else begin
      vs_q         <= vga_vs;
      mode_q       <= mode_d;
      mode_pend_q  <= mode_pend_d;
      thr_q        <= thr_d;
      thr_stage_q  <= thr_stage_d;
      cfg_update_q <= cfg_update_d;
    end
  end

  assign mode         = mode_q;
  assign mode_pending = mode_pend_q;
  assign threshold    = thr_q;
  assign cfg_update   = cfg_update_q;

endmodule
